instr_fifo_fwft: RTL and testbench



---
 rtl/instr_fifo_fwft.sv | 109 ++++++++++
 tb/tb_instr_fifo_fwft.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fifo_fwft.sv
// Instruction-queue FIFO with first-word-fall-through head, occupancy count and threshold flags.
// Define INSTR_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module instr_fifo_fwft #(
    parameter int FIFO_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] in,
    input  logic                  write_en,
    input  logic                  next_en,
    input  logic                  flush,
    output logic [FIFO_WIDTH-1:0] out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
`ifdef INSTR_FIFO_ERR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] ram [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  wr_fire;
    logic                  rd_fire;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty        = (cnt_reg == '0);
    assign full         = (cnt_reg == CNT_W'(FIFO_DEPTH));
    assign almost_full  = (cnt_reg >= CNT_W'(AF_THRESH));
    assign almost_empty = (cnt_reg <= CNT_W'(AE_THRESH));
    assign count        = cnt_reg;

    assign wr_fire = write_en & ~full;
    assign rd_fire = next_en & ~empty;

    assign out = empty ? '0 : ram[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (wr_fire && !flush) begin
            ram[wr_ptr_reg] <= in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (rd_fire) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({wr_fire, rd_fire})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

`ifdef INSTR_FIFO_ERR_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (flush) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (write_en && full) begin
                overflow_reg <= 1'b1;
            end
            if (next_en && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_instr_fifo_fwft.sv
// Bench for instr_fifo_fwft at DEPTH=5: reset, directed vector table, wrap run and random run vs a queue model.
module tb_instr_fifo_fwft;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  din = '0;
    logic          write_en = 1'b0;
    logic          next_en = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  dout;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    instr_fifo_fwft #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (D),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (din),
        .write_en     (write_en),
        .next_en      (next_en),
        .flush        (flush),
        .out          (dout),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef INSTR_FIFO_ERR_FLAGS_EN
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .count        (count)
    );

`ifndef INSTR_FIFO_ERR_FLAGS_EN
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int ecnt, input logic [W-1:0] eout,
                             input logic eemp, input logic eful, input logic eaf, input logic eae);
        chk({tag, " count"}, 32'(count), 32'(ecnt));
        chk({tag, " out"}, 32'(dout), 32'(eout));
        chk({tag, " empty"}, 32'(empty), 32'(eemp));
        chk({tag, " full"}, 32'(full), 32'(eful));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(eaf));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(eae));
    endtask

    task automatic step(input logic wr, input logic [W-1:0] d, input logic nx, input logic fl);
        @(negedge clk);
        write_en = wr;
        din      = d;
        next_en  = nx;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    // Reference: a queue of entries plus sticky error bits.
    logic [W-1:0] q[$];
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    task automatic model_step(input string tag, input logic wr, input logic [W-1:0] d,
                              input logic nx, input logic fl);
        int n;
        logic [W-1:0] eo;
        n = q.size();
        step(wr, d, nx, fl);
        if (fl) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wr && n == D) m_ovf = 1'b1;
            if (nx && n == 0) m_unf = 1'b1;
            if (nx && n > 0) void'(q.pop_front());
            if (wr && n < D) q.push_back(d);
        end
        n  = q.size();
        eo = (n > 0) ? q[0] : '0;
        chk_state(tag, n, eo, n == 0, n == D, n >= AF, n <= AE);
        chk({tag, " count<=DEPTH"}, 32'(count <= CW'(D)), 32'd1);
`ifdef INSTR_FIFO_ERR_FLAGS_EN
        chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, " underflow"}, 32'(underflow), 32'(m_unf));
`endif
        $display("[TB] %s wr=%0d d=%h nx=%0d fl=%0d count=%0d out=%h", tag, wr, d, nx, fl, count, dout);
    endtask

    typedef struct {
        logic         wr;
        logic [W-1:0] d;
        logic         nx;
        logic         fl;
        int           cnt;
        logic [W-1:0] q;
        logic         emp, ful, af, ae, ovf, unf;
    } vec_t;

    vec_t vecs[28];

    initial begin
        string tag;

        // wr, d, nx, fl, count, out, empty, full, af, ae, ovf, unf
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 2, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h13, 1'b0, 1'b0, 3, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h14, 1'b0, 1'b0, 4, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h15, 1'b0, 1'b0, 5, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h99, 1'b0, 1'b0, 5, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'hA1, 1'b1, 1'b0, 3, 8'h14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 3, 8'h15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'hA3, 1'b0, 1'b0, 4, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'hA4, 1'b0, 1'b0, 5, 8'h15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'hB0, 1'b1, 1'b0, 4, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{1'b1, 8'hC1, 1'b1, 1'b0, 1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 8'hC2, 1'b0, 1'b0, 2, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{1'b1, 8'hC3, 1'b0, 1'b0, 3, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[21] = '{1'b1, 8'hC4, 1'b0, 1'b0, 4, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[22] = '{1'b1, 8'hD0, 1'b0, 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[24] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[26] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[27] = '{1'b1, 8'hE1, 1'b0, 1'b0, 1, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Power-on reset, then release and put two entries in.
        #2;
        chk_state("por", 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h5B, 1'b0, 1'b0);
        chk_state("pre_reset", 2, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset asserted mid-cycle with a push request pending.
        @(negedge clk);
        write_en = 1'b1;
        din      = 8'h77;
        #2;
        rst = 1'b0;
        #1;
        chk_state("in_reset", 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk_state($sformatf("hold_reset%0d", i), 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        write_en = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        chk_state("post_reset", 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef INSTR_FIFO_ERR_FLAGS_EN
        chk("post_reset overflow", 32'(overflow), 32'd0);
        chk("post_reset underflow", 32'(underflow), 32'd0);
`endif

        // Directed vector table.
        for (int i = 0; i < 28; i++) begin
            step(vecs[i].wr, vecs[i].d, vecs[i].nx, vecs[i].fl);
            tag = $sformatf("vec%0d", i);
            chk_state(tag, vecs[i].cnt, vecs[i].q, vecs[i].emp, vecs[i].ful, vecs[i].af, vecs[i].ae);
`ifdef INSTR_FIFO_ERR_FLAGS_EN
            chk({tag, " overflow"}, 32'(overflow), 32'(vecs[i].ovf));
            chk({tag, " underflow"}, 32'(underflow), 32'(vecs[i].unf));
`endif
            $display("[TB] %s wr=%0d d=%h nx=%0d fl=%0d count=%0d out=%h",
                     tag, vecs[i].wr, vecs[i].d, vecs[i].nx, vecs[i].fl, count, dout);
        end

        // Model-checked phases start from a flushed FIFO.
        model_step("sync_flush", 1'b0, 8'h00, 1'b0, 1'b1);

        // Wrap run: 13 pushes interleaved with pops so both pointers pass the last slot twice.
        for (int i = 1; i <= 13; i++) begin
            model_step($sformatf("wrap%0d", i), 1'b1, 8'(i), i > 2, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            model_step($sformatf("wrap_drain%0d", i), 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            model_step($sformatf("rnd%0d", i), ($urandom_range(0, 99) < 60), 8'($urandom),
                       ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
